// File: rtl/vga_pkg.sv
// vga_pkg: shared sizing helpers and the rectangle record used by the
// VGA rectangle renderer and its timing generator.
//
// Contents:
//   COORD_W / COLOR_W - storage widths of a rectangle record.
//   line_total()      - sum of the four segments of a line or frame.
//   cnt_width()       - counter width for a modulus (minimum 1 bit).
//   rect_t            - packed rectangle {en, xmin, xmax, ymin, ymax, color}.
package vga_pkg;

   // Record fields are sized for the largest supported geometry and colour
   // depth. Narrower instances zero-extend into the record, and synthesis
   // strips the constant upper bits.
   localparam int COORD_W = 16;
   localparam int COLOR_W = 24;

   function automatic int line_total(
      input int vis,
      input int fp,
      input int sync,
      input int bp
   );
      return vis + fp + sync + bp;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic               en;
      logic [COORD_W-1:0] xmin;
      logic [COORD_W-1:0] xmax;
      logic [COORD_W-1:0] ymin;
      logic [COORD_W-1:0] ymax;
      logic [COLOR_W-1:0] color;
   } rect_t;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-rate divider, h/v raster counters and sync/blank decode
// for the pixel at the current (h,v).
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset.
//   pen               - pixel enable, one clk in every CLK_DIV.
//   h, v              - raster position sampled on the next pen.
//   last_pixel        - (h,v) is the final pixel of the frame.
//   blank_d           - (h,v) lies outside the visible area.
//   hsync_d, vsync_d  - sync levels for (h,v), polarity applied.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV   = 5,
   parameter int H_VISIBLE = 400,
   parameter int H_FP      = 20,
   parameter int H_SYNC    = 64,
   parameter int H_BP      = 44,
   parameter int V_VISIBLE = 600,
   parameter int V_FP      = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 23,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   localparam int H_TOTAL  = line_total(H_VISIBLE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL  = line_total(V_VISIBLE, V_FP, V_SYNC, V_BP),
   localparam int XW       = cnt_width(H_TOTAL),
   localparam int YW       = cnt_width(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          pen,
   output logic [XW-1:0] h,
   output logic [YW-1:0] v,
   output logic          last_pixel,
   output logic          blank_d,
   output logic          hsync_d,
   output logic          vsync_d
);

   localparam int DW = cnt_width(CLK_DIV);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

   // Decode thresholds kept 32 bits wide so a sync pulse that runs to the
   // end of the line (zero back porch) never wraps in a narrow compare.
   localparam logic [31:0] H_VIS = 32'(H_VISIBLE);
   localparam logic [31:0] HS_ON = 32'(H_VISIBLE + H_FP);
   localparam logic [31:0] HS_NO = 32'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [31:0] V_VIS = 32'(V_VISIBLE);
   localparam logic [31:0] VS_ON = 32'(V_VISIBLE + V_FP);
   localparam logic [31:0] VS_NO = 32'(V_VISIBLE + V_FP + V_SYNC);

   logic [DW-1:0] div;
   logic          h_last;
   logic          v_last;
   logic [31:0]   hx;
   logic [31:0]   vy;
   logic          in_hs;
   logic          in_vs;

   assign pen        = (div == DIV_LAST);
   assign h_last     = (h == H_LAST);
   assign v_last     = (v == V_LAST);
   assign last_pixel = h_last && v_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
         h   <= '0;
         v   <= '0;
      end else begin
         div <= pen ? '0 : div + 1'b1;
         if (pen) begin
            h <= h_last ? '0 : h + 1'b1;
            if (h_last) begin
               v <= v_last ? '0 : v + 1'b1;
            end
         end
      end
   end

   assign hx = 32'(h);
   assign vy = 32'(v);

   assign in_hs = (hx >= HS_ON) && (hx < HS_NO);
   assign in_vs = (vy >= VS_ON) && (vy < VS_NO);

   assign blank_d = (hx >= H_VIS) || (vy >= V_VIS);
   assign hsync_d = in_hs ? HSYNC_POL : ~HSYNC_POL;
   assign vsync_d = in_vs ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: rtl/vga_rect_renderer.sv
// vga_rect_renderer: VGA timing plus a prioritised rectangle compositor.
// Rectangle geometry is shadowed once per frame; background is live.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset.
//   rect_en             - per-rectangle enable (bit i = rectangle i).
//   rect_xmin/xmax      - inclusive x bounds, XW bits each, index 0 in LSBs.
//   rect_ymin/ymax      - inclusive y bounds, YW bits each.
//   rect_color          - {r,g,b} per rectangle, CW bits each.
//   bg_color            - visible-area background {r,g,b}.
//   r, g, b             - registered pixel colour.
//   hsync, vsync, blank - registered sync and blanking.
//   px_x, px_y          - coordinate of the pixel being presented.
//   frame_start         - one-clk pulse when pixel (0,0) is presented.
module vga_rect_renderer
   import vga_pkg::*;
#(
   parameter int CLK_DIV    = 5,
   parameter int H_VISIBLE  = 400,
   parameter int H_FP       = 20,
   parameter int H_SYNC     = 64,
   parameter int H_BP       = 44,
   parameter int V_VISIBLE  = 600,
   parameter int V_FP       = 1,
   parameter int V_SYNC     = 4,
   parameter int V_BP       = 23,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int NUM_RECTS  = 4,
   parameter int COLOR_BITS = 1,
   localparam int H_TOTAL   = line_total(H_VISIBLE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL   = line_total(V_VISIBLE, V_FP, V_SYNC, V_BP),
   localparam int XW        = cnt_width(H_TOTAL),
   localparam int YW        = cnt_width(V_TOTAL),
   localparam int CW        = 3 * COLOR_BITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_RECTS-1:0]    rect_en,
   input  logic [NUM_RECTS*XW-1:0] rect_xmin,
   input  logic [NUM_RECTS*XW-1:0] rect_xmax,
   input  logic [NUM_RECTS*YW-1:0] rect_ymin,
   input  logic [NUM_RECTS*YW-1:0] rect_ymax,
   input  logic [NUM_RECTS*CW-1:0] rect_color,
   input  logic [CW-1:0]           bg_color,
   output logic [COLOR_BITS-1:0]   r,
   output logic [COLOR_BITS-1:0]   g,
   output logic [COLOR_BITS-1:0]   b,
   output logic                    hsync,
   output logic                    vsync,
   output logic                    blank,
   output logic [XW-1:0]           px_x,
   output logic [YW-1:0]           px_y,
   output logic                    frame_start
);

   logic          pen;
   logic [XW-1:0] h;
   logic [YW-1:0] v;
   logic          last_pixel;
   logic          blank_d;
   logic          hsync_d;
   logic          vsync_d;

   vga_timing #(
      .CLK_DIV   (CLK_DIV),
      .H_VISIBLE (H_VISIBLE),
      .H_FP      (H_FP),
      .H_SYNC    (H_SYNC),
      .H_BP      (H_BP),
      .V_VISIBLE (V_VISIBLE),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP),
      .HSYNC_POL (HSYNC_POL),
      .VSYNC_POL (VSYNC_POL)
   ) u_timing (
      .clk        (clk),
      .rst        (rst),
      .pen        (pen),
      .h          (h),
      .v          (v),
      .last_pixel (last_pixel),
      .blank_d    (blank_d),
      .hsync_d    (hsync_d),
      .vsync_d    (vsync_d)
   );

   rect_t              live   [NUM_RECTS];
   rect_t              shadow [NUM_RECTS];
   logic [NUM_RECTS-1:0] hit;
   logic [COORD_W-1:0] hx;
   logic [COORD_W-1:0] vy;
   logic [CW-1:0]      pix_color;

   // Unflatten the port buses into records.
   always_comb begin
      for (int i = 0; i < NUM_RECTS; i++) begin
         live[i]       = '0;
         live[i].en    = rect_en[i];
         live[i].xmin  = COORD_W'(rect_xmin[i*XW +: XW]);
         live[i].xmax  = COORD_W'(rect_xmax[i*XW +: XW]);
         live[i].ymin  = COORD_W'(rect_ymin[i*YW +: YW]);
         live[i].ymax  = COORD_W'(rect_ymax[i*YW +: YW]);
         live[i].color = COLOR_W'(rect_color[i*CW +: CW]);
      end
   end

   // Capture on the final pixel of the frame so the whole next frame sees
   // one consistent geometry, whatever the game logic does mid-frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_RECTS; i++) begin
            shadow[i] <= '0;
         end
      end else if (pen && last_pixel) begin
         for (int i = 0; i < NUM_RECTS; i++) begin
            shadow[i] <= live[i];
         end
      end
   end

   assign hx = COORD_W'(h);
   assign vy = COORD_W'(v);

   // Inverted bounds fail one of the two compares, so empty rectangles
   // fall out of the hit test without special handling.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_RECTS; i++) begin
         hit[i] = shadow[i].en
               && (shadow[i].xmin <= hx) && (hx <= shadow[i].xmax)
               && (shadow[i].ymin <= vy) && (vy <= shadow[i].ymax);
      end
   end

   // Walking downwards lets the lowest-index hit win.
   always_comb begin
      pix_color = bg_color;
      for (int i = NUM_RECTS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            pix_color = CW'(shadow[i].color);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r           <= '0;
         g           <= '0;
         b           <= '0;
         blank       <= 1'b1;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         px_x        <= '0;
         px_y        <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (pen) begin
            {r, g, b}   <= blank_d ? '0 : pix_color;
            blank       <= blank_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            px_x        <= h;
            px_y        <= v;
            frame_start <= (h == '0) && (v == '0);
         end
      end
   end

endmodule

// File: tb/tb_vga_rect_renderer.sv
// tb_vga_rect_renderer: directed bench with a time-based raster model.
// Small raster, CLK_DIV=2, 4-bit colour, 8 rectangles, active-high hsync.
module tb_vga_rect_renderer;

   localparam int D    = 2;
   localparam int HV   = 40;
   localparam int HFP  = 4;
   localparam int HS   = 8;
   localparam int HBP  = 4;
   localparam int VV   = 30;
   localparam int VFP  = 1;
   localparam int VS   = 2;
   localparam int VBP  = 3;
   localparam bit HPOL = 1'b1;
   localparam bit VPOL = 1'b0;
   localparam int NR   = 8;
   localparam int CB   = 4;
   localparam int HT   = HV + HFP + HS + HBP;
   localparam int VT   = VV + VFP + VS + VBP;
   localparam int XW   = $clog2(HT);
   localparam int YW   = $clog2(VT);
   localparam int CW   = 3 * CB;
   localparam int FRAME = HT * VT * D;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    rect_en;
   logic [NR*XW-1:0] rect_xmin;
   logic [NR*XW-1:0] rect_xmax;
   logic [NR*YW-1:0] rect_ymin;
   logic [NR*YW-1:0] rect_ymax;
   logic [NR*CW-1:0] rect_color;
   logic [CW-1:0]    bg_color;
   logic [CB-1:0]    r;
   logic [CB-1:0]    g;
   logic [CB-1:0]    b;
   logic             hsync;
   logic             vsync;
   logic             blank;
   logic [XW-1:0]    px_x;
   logic [YW-1:0]    px_y;
   logic             frame_start;

   always #5 clk = ~clk;

   vga_rect_renderer #(
      .CLK_DIV    (D),
      .H_VISIBLE  (HV),
      .H_FP       (HFP),
      .H_SYNC     (HS),
      .H_BP       (HBP),
      .V_VISIBLE  (VV),
      .V_FP       (VFP),
      .V_SYNC     (VS),
      .V_BP       (VBP),
      .HSYNC_POL  (HPOL),
      .VSYNC_POL  (VPOL),
      .NUM_RECTS  (NR),
      .COLOR_BITS (CB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rect_en     (rect_en),
      .rect_xmin   (rect_xmin),
      .rect_xmax   (rect_xmax),
      .rect_ymin   (rect_ymin),
      .rect_ymax   (rect_ymax),
      .rect_color  (rect_color),
      .bg_color    (bg_color),
      .r           (r),
      .g           (g),
      .b           (b),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .px_x        (px_x),
      .px_y        (px_y),
      .frame_start (frame_start)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit chk_on = 1'b0;

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                    nm, got, exp, cyc);
   endtask

   // Model: pure raster arithmetic from the number of clocks since reset.
   int            sh_en [NR];
   int            sh_x0 [NR];
   int            sh_x1 [NR];
   int            sh_y0 [NR];
   int            sh_y1 [NR];
   logic [CW-1:0] sh_c  [NR];
   logic [CW-1:0] exp_rgb;
   logic          exp_hs;
   logic          exp_vs;
   logic          exp_bl;
   logic          exp_fs;
   int            exp_x;
   int            exp_y;

   function automatic logic [CW-1:0] pick(input int x, input int y);
      for (int i = 0; i < NR; i++) begin
         if (sh_en[i] != 0 && x >= sh_x0[i] && x <= sh_x1[i]
             && y >= sh_y0[i] && y <= sh_y1[i]) return sh_c[i];
      end
      return bg_color;
   endfunction

   initial begin : model
      int e;
      int k;
      int hh;
      int vv;
      e = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            e = 0;
            exp_rgb = '0;
            exp_bl = 1'b1;
            exp_hs = ~HPOL;
            exp_vs = ~VPOL;
            exp_x = 0;
            exp_y = 0;
            exp_fs = 1'b0;
            for (int i = 0; i < NR; i++) sh_en[i] = 0;
         end else begin
            e++;
            exp_fs = 1'b0;
            if (e % D == 0) begin
               k = e / D - 1;
               hh = k % HT;
               vv = (k / HT) % VT;
               exp_x = hh;
               exp_y = vv;
               exp_bl = (hh >= HV) || (vv >= VV);
               exp_hs = (hh >= HV + HFP && hh < HV + HFP + HS)
                        ? HPOL : ~HPOL;
               exp_vs = (vv >= VV + VFP && vv < VV + VFP + VS)
                        ? VPOL : ~VPOL;
               exp_rgb = exp_bl ? '0 : pick(hh, vv);
               exp_fs = (k % (HT * VT)) == 0;
               if (hh == HT - 1 && vv == VT - 1) begin
                  for (int i = 0; i < NR; i++) begin
                     sh_en[i] = int'(rect_en[i]);
                     sh_x0[i] = int'(rect_xmin[i*XW +: XW]);
                     sh_x1[i] = int'(rect_xmax[i*XW +: XW]);
                     sh_y0[i] = int'(rect_ymin[i*YW +: YW]);
                     sh_y1[i] = int'(rect_ymax[i*YW +: YW]);
                     sh_c[i]  = rect_color[i*CW +: CW];
                  end
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (chk_on) begin
            check("cycle_out",
                  {4'h0, r, g, b, hsync, vsync, blank,
                   px_x, px_y, frame_start},
                  {4'h0, exp_rgb, exp_hs, exp_vs, exp_bl,
                   XW'(exp_x), YW'(exp_y), exp_fs});
         end
      end
   end

   task automatic set_rect(input int i, input bit en, input int x0,
                           input int x1, input int y0, input int y1,
                           input logic [CW-1:0] c);
      rect_en[i]            = en;
      rect_xmin[i*XW +: XW] = XW'(x0);
      rect_xmax[i*XW +: XW] = XW'(x1);
      rect_ymin[i*YW +: YW] = YW'(y0);
      rect_ymax[i*YW +: YW] = YW'(y1);
      rect_color[i*CW +: CW] = c;
   endtask

   task automatic wait_sig(input int which, input logic val,
                           output int n);
      logic s;
      n = -1;
      for (int i = 1; i <= 2 * FRAME; i++) begin
         @(negedge clk);
         case (which)
            0:       s = hsync;
            1:       s = vsync;
            default: s = frame_start;
         endcase
         if (s == val) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic px_check(input string nm, input int x, input int y,
                           input logic [CW-1:0] c, input logic bl);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (int'(px_x) == x && int'(px_y) == y) begin
            ok = 1'b1;
            break;
         end
      end
      check({nm, "_found"}, 32'(ok), 32'd1);
      check({nm, "_rgb"}, 32'({r, g, b}), 32'(c));
      check({nm, "_blank"}, 32'(blank), 32'(bl));
   endtask

   task automatic reset_check(input string nm);
      check({nm, "_blank"}, 32'(blank), 32'd1);
      check({nm, "_hsync"}, 32'(hsync), 32'd0);
      check({nm, "_vsync"}, 32'(vsync), 32'd1);
      check({nm, "_rgb"}, 32'({r, g, b}), 32'd0);
      check({nm, "_fs"}, 32'(frame_start), 32'd0);
   endtask

   initial begin : stim
      int n;
      int n_hi;
      int n_lo;
      int t0;
      rst = 1'b1;
      rect_en = '0;
      rect_xmin = '0;
      rect_xmax = '0;
      rect_ymin = '0;
      rect_ymax = '0;
      rect_color = '0;
      bg_color = '0;
      set_rect(0, 1'b1, 10, 19, 10, 19, 12'hF00);
      set_rect(1, 1'b1, 15, 24, 10, 19, 12'h0F0);
      set_rect(2, 1'b1, 30, 20, 0, 29, 12'h00F);
      set_rect(3, 1'b0, 0, 55, 0, 35, 12'hFFF);
      set_rect(4, 1'b1, 36, 50, 0, 5, 12'h0FF);
      set_rect(5, 1'b1, 0, 55, 25, 20, 12'hF0F);
      set_rect(6, 1'b1, 60, 63, 0, 35, 12'h888);
      set_rect(7, 1'b1, 30, 35, 20, 25, 12'hA5C);
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      reset_check("reset");
      check("reset_px", 32'({px_x, px_y}), 32'd0);
      rst = 1'b0;

      wait_sig(2, 1'b1, n);
      check("first_fs_latency", 32'(n), 32'd2);
      t0 = cyc;
      wait_sig(0, 1'b1, n);
      check("hsync_start", 32'(n), 32'd88);
      wait_sig(0, 1'b0, n_hi);
      check("hsync_width", 32'(n_hi), 32'd16);
      wait_sig(0, 1'b1, n_lo);
      check("line_period", 32'(n_hi + n_lo), 32'd112);
      wait_sig(2, 1'b1, n);
      check("frame_period", 32'(cyc - t0), 32'd4032);
      t0 = cyc;
      wait_sig(1, 1'b0, n);
      check("vsync_start", 32'(n), 32'd3472);
      wait_sig(1, 1'b1, n);
      check("vsync_width", 32'(n), 32'd224);
      wait_sig(2, 1'b1, n);
      check("frame_period2", 32'(cyc - t0), 32'd4032);

      px_check("edge_vis", 39, 2, 12'h0FF, 1'b0);
      px_check("edge_blank", 45, 2, 12'h000, 1'b1);
      px_check("bg_px", 5, 12, 12'h000, 1'b0);
      px_check("ovl_red", 15, 12, 12'hF00, 1'b0);
      px_check("ovl_green", 22, 12, 12'h0F0, 1'b0);
      px_check("rect7", 32, 22, 12'hA5C, 1'b0);
      px_check("empty_rects", 25, 25, 12'h000, 1'b0);

      wait_sig(2, 1'b1, n);
      px_check("move_pt", 0, 15, 12'h000, 1'b0);
      set_rect(0, 1'b1, 30, 39, 10, 19, 12'hF00);
      px_check("old_geom", 12, 17, 12'hF00, 1'b0);
      wait_sig(2, 1'b1, n);
      px_check("old_gone", 12, 12, 12'h000, 1'b0);
      px_check("new_geom", 32, 12, 12'hF00, 1'b0);

      px_check("rst_pt", 0, 20, 12'h000, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      reset_check("mid_reset");
      rst = 1'b0;
      wait_sig(2, 1'b1, n);
      check("fs_after_rst", 32'(n), 32'd2);
      t0 = cyc;
      px_check("shadow_clr", 32, 12, 12'h000, 1'b0);
      bg_color = 12'h321;
      wait_sig(2, 1'b1, n);
      check("frame_after_rst", 32'(cyc - t0), 32'd4032);
      px_check("bg_live", 5, 5, 12'h321, 1'b0);
      px_check("shadow_back", 32, 12, 12'hF00, 1'b0);

      repeat (20) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
